// File: rtl/bram_uart_dump.sv
// bram_uart_dump
//   Streams a contiguous block of 8-bit samples out of a BRAM read port and
//   hands them one byte at a time to a uart_transmit-style byte interface.
//   Addresses wrap modulo BRAM_DEPTH; the requested length is clamped to
//   BRAM_DEPTH.
//
//   Optional feature macro: DUMP_CHECKSUM_EN
//     When defined, an 8-bit running sum of the data bytes is appended as one
//     extra byte after the data (not counted in count_out). A zero-length dump
//     then sends a single 0x00.
//
// Parameters
//   BRAM_DEPTH    number of BRAM words (address wrap modulus)
//   ADDR_WIDTH    width of address ports; length/count ports are one bit wider
//   READ_LATENCY  cycles from addr_out change to valid data_in (1..4)
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   start_in        one-cycle start request, honoured only when idle
//   start_addr_in   first BRAM address, sampled with start_in
//   length_in       number of data bytes, sampled with start_in
//   addr_out        BRAM read address
//   data_in         BRAM read data
//   tx_byte_out     byte presented to the transmitter
//   tx_trigger_out  one-cycle pulse: transmitter takes tx_byte_out
//   tx_busy_in      transmitter busy
//   busy_out        high while a dump is in progress
//   done_out        one-cycle pulse when a dump completes
//   count_out       data bytes handed off in the current dump

module bram_uart_dump #(
    parameter int BRAM_DEPTH   = 40_000,
    parameter int ADDR_WIDTH   = $clog2(BRAM_DEPTH),
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] start_addr_in,
    input  logic [ADDR_WIDTH:0]   length_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [7:0]            data_in,
    output logic [7:0]            tx_byte_out,
    output logic                  tx_trigger_out,
    input  logic                  tx_busy_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [ADDR_WIDTH:0]   count_out
);

    localparam logic [ADDR_WIDTH:0] DEPTH    = (ADDR_WIDTH+1)'(BRAM_DEPTH);
    localparam logic [2:0]          LAT_LAST = 3'(READ_LATENCY);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, HOLD, WAIT, FINISH, CSUM} state_t;
    localparam state_t AFTER_DATA = CSUM;
`else
    typedef enum logic [2:0] {IDLE, READ, SEND, HOLD, WAIT, FINISH} state_t;
    localparam state_t AFTER_DATA = FINISH;
`endif

    state_t              state;
    state_t              next_state;
    logic [ADDR_WIDTH:0] length;
    logic [ADDR_WIDTH:0] clamped;
    logic [ADDR_WIDTH:0] addr_inc;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [2:0]          lat_cnt;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]          sum;
    logic                csum_phase;
`endif

    always_comb begin
        clamped = (length_in > DEPTH) ? DEPTH : length_in;
    end

    // Increment one bit wider than the address so the wrap compare against
    // BRAM_DEPTH works even when BRAM_DEPTH is a power of two.
    always_comb begin
        addr_inc  = {1'b0, addr_out} + 1'b1;
        addr_next = (addr_inc == DEPTH) ? '0 : addr_inc[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_in) begin
                    next_state = (clamped == '0) ? AFTER_DATA : READ;
                end
            end
            // The latency counter runs 0..READ_LATENCY so data_in is sampled
            // one edge after it is guaranteed valid.
            READ: begin
                if (lat_cnt == LAT_LAST) begin
                    next_state = SEND;
                end
            end
            SEND: next_state = HOLD;
            // tx_busy_in is not yet updated by the transmitter here.
            HOLD: next_state = WAIT;
            WAIT: begin
                if (!tx_busy_in) begin
`ifdef DUMP_CHECKSUM_EN
                    if (csum_phase) begin
                        next_state = FINISH;
                    end else if (count_out == length) begin
                        next_state = CSUM;
                    end else begin
                        next_state = READ;
                    end
`else
                    if (count_out == length) begin
                        next_state = FINISH;
                    end else begin
                        next_state = READ;
                    end
`endif
                end
            end
            FINISH: next_state = IDLE;
`ifdef DUMP_CHECKSUM_EN
            CSUM: next_state = SEND;
`endif
            default: next_state = IDLE;
        endcase
    end

    // busy_out drops in FINISH so it falls on the same edge done_out rises;
    // this also keeps a start during the done cycle from being accepted.
    always_comb begin
        tx_trigger_out = (state == SEND);
        done_out       = (state == FINISH);
        busy_out       = (state != IDLE) && (state != FINISH);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_out    <= '0;
            length      <= '0;
            count_out   <= '0;
            lat_cnt     <= '0;
            tx_byte_out <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum         <= '0;
            csum_phase  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        addr_out   <= start_addr_in;
                        length     <= clamped;
                        count_out  <= '0;
                        lat_cnt    <= '0;
`ifdef DUMP_CHECKSUM_EN
                        sum        <= '0;
                        csum_phase <= 1'b0;
`endif
                    end
                end
                READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        tx_byte_out <= data_in;
                        lat_cnt     <= '0;
`ifdef DUMP_CHECKSUM_EN
                        sum         <= sum + data_in;
`endif
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                SEND: begin
`ifdef DUMP_CHECKSUM_EN
                    if (!csum_phase) begin
                        count_out <= count_out + 1'b1;
                        addr_out  <= addr_next;
                    end
`else
                    count_out <= count_out + 1'b1;
                    addr_out  <= addr_next;
`endif
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    tx_byte_out <= sum;
                    csum_phase  <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_uart_dump.sv
module tb_bram_uart_dump;

    localparam int DEPTH = 40000;
    localparam int AW    = 16;
    localparam int RL    = 2;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] addr;
    logic [7:0]    data = '0;
    logic [7:0]    tx_byte;
    logic          trig;
    logic          busy_tx;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    // reduced-depth instance for the length clamp
    logic          start2 = 1'b0;
    logic [6:0]    start_addr2 = '0;
    logic [7:0]    length2 = '0;
    logic [6:0]    addr2;
    logic [7:0]    data2 = '0;
    logic [7:0]    tx_byte2;
    logic          trig2;
    logic          busy2;
    logic          done2;
    logic [7:0]    count2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_uart_dump #(.BRAM_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .start_addr_in(start_addr),
        .length_in(length), .addr_out(addr), .data_in(data), .tx_byte_out(tx_byte),
        .tx_trigger_out(trig), .tx_busy_in(busy_tx), .busy_out(busy),
        .done_out(done), .count_out(count)
    );

    bram_uart_dump #(.BRAM_DEPTH(100), .READ_LATENCY(1)) dut2 (
        .clk_in(clk), .rst_in(rst), .start_in(start2), .start_addr_in(start_addr2),
        .length_in(length2), .addr_out(addr2), .data_in(data2), .tx_byte_out(tx_byte2),
        .tx_trigger_out(trig2), .tx_busy_in(1'b0), .busy_out(busy2),
        .done_out(done2), .count_out(count2)
    );

    // BRAM model with two-cycle read latency
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] r1 = '0;
    always @(posedge clk) begin
        r1   <= mem[addr];
        data <= r1;
    end
    always @(posedge clk) data2 <= {1'b0, addr2};

    // transmitter model
    int   busy_len  = 20;
    logic late      = 1'b0;
    logic late_pend = 1'b0;
    int   busy_cnt  = 0;
    always @(posedge clk) begin
        if (trig) begin
            if (late) late_pend <= 1'b1;
            else      busy_cnt  <= busy_len;
        end else if (late_pend) begin
            late_pend <= 1'b0;
            busy_cnt  <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign busy_tx = (busy_cnt != 0);

    // monitor
    logic [7:0] byte_q[$];
    int addr_q[$];
    int cyc_q[$];
    int n_trig = 0, n_done = 0, n_double = 0;
    int done_cyc = 0, done_count = 0, done_busy = 0;
    logic prev_trig = 1'b0;
    logic [7:0] byte2_q[$];
    int n_done2 = 0, done_count2 = 0;

    always @(negedge clk) begin
        if (trig) begin
            byte_q.push_back(tx_byte);
            addr_q.push_back(int'(addr));
            cyc_q.push_back(cyc);
            n_trig++;
            if (prev_trig) n_double++;
        end
        prev_trig = trig;
        if (done) begin
            n_done++;
            done_cyc   = cyc;
            done_count = int'(count);
            done_busy  = int'(busy);
        end
        if (trig2) byte2_q.push_back(tx_byte2);
        if (done2) begin
            n_done2++;
            done_count2 = int'(count2);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        byte_q.delete();
        addr_q.delete();
        cyc_q.delete();
        n_trig   = 0;
        n_done   = 0;
        n_double = 0;
    endtask

    task automatic start_dump(input int a, input int len, output int e0);
        @(negedge clk);
        start      = 1'b1;
        start_addr = AW'(a);
        length     = (AW+1)'(len);
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int d0;
        int i;
        d0 = n_done;
        i  = 0;
        while (n_done == d0 && i < max_cycles) begin
            @(negedge clk);
            #1;
            i++;
        end
        check(tag, n_done - d0, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_trig"}, int'(trig), 0);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_addr"}, int'(addr), 0);
        check({tag, "_byte"}, int'(tx_byte), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int i;
        mem[0]     = 8'h11; mem[1]     = 8'h22; mem[2]  = 8'h33; mem[3]  = 8'h44;
        mem[39998] = 8'hA1; mem[39999] = 8'hA2;
        mem[10]    = 8'h5A; mem[11]    = 8'hA5; mem[12] = 8'h3C;
        mem[20]    = 8'hF0; mem[21]    = 8'h20; mem[5]  = 8'h77;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic dump
        clear_mon();
        start_dump(0, 4, e0);
        check("basic_addr_e0", int'(addr), 0);
        check("basic_busy_e0", int'(busy), 1);
        wait_done("basic_done", 400);
        check("basic_ntrig", n_trig, 4 + EXTRA);
        check("basic_b0", int'(byte_q[0]), 'h11);
        check("basic_b1", int'(byte_q[1]), 'h22);
        check("basic_b2", int'(byte_q[2]), 'h33);
        check("basic_b3", int'(byte_q[3]), 'h44);
        check("basic_first_lat", cyc_q[0] - e0, RL + 1);
        check("basic_count", done_count, 4);
        check("basic_busy_at_done", done_busy, 0);
        check("basic_double", n_double, 0);

        // wrap-around
        clear_mon();
        start_dump(39998, 4, e0);
        check("wrap_addr_e0", int'(addr), 39998);
        wait_done("wrap_done", 400);
        check("wrap_a0", addr_q[0], 39998);
        check("wrap_a1", addr_q[1], 39999);
        check("wrap_a2", addr_q[2], 0);
        check("wrap_a3", addr_q[3], 1);
        check("wrap_b1", int'(byte_q[1]), 'hA2);
        check("wrap_b2", int'(byte_q[2]), 'h11);

        // length 0, start held into the done cycle
        clear_mon();
        @(negedge clk);
        start      = 1'b1;
        start_addr = AW'(5);
        length     = '0;
        @(posedge clk);
        #1;
        e0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("len0_ndone", n_done, 1);
        check("len0_ntrig", n_trig, EXTRA);
        check("len0_busy", int'(busy), 0);
`ifndef DUMP_CHECKSUM_EN
        check("len0_done_cyc", done_cyc - e0, 0);
`endif

        // clamp on the reduced-depth instance
        @(negedge clk);
        start2      = 1'b1;
        start_addr2 = '0;
        length2     = 8'd150;
        @(negedge clk);
        start2 = 1'b0;
        i = 0;
        while (n_done2 == 0 && i < 2000) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("clamp_done", n_done2, 1);
        check("clamp_ntrig", byte2_q.size(), 100 + EXTRA);
        check("clamp_count", done_count2, 100);
        check("clamp_last", int'(byte2_q[99]), 99);

        // late busy and start while busy
        clear_mon();
        late = 1'b1;
        start_dump(10, 3, e0);
        repeat (12) @(negedge clk);
        start      = 1'b1;
        start_addr = '0;
        length     = (AW+1)'(1);
        @(negedge clk);
        start = 1'b0;
        wait_done("late_done", 400);
        check("late_ntrig", n_trig, 3 + EXTRA);
        check("late_b0", int'(byte_q[0]), 'h5A);
        check("late_b1", int'(byte_q[1]), 'hA5);
        check("late_b2", int'(byte_q[2]), 'h3C);
        check("late_a2", addr_q[2], 12);
        check("late_double", n_double, 0);
        late = 1'b0;
        repeat (40) @(negedge clk);
        check("late_no_restart", n_done, 1);

        // reset mid-dump
        clear_mon();
        start_dump(0, 4, e0);
        i = 0;
        while (n_trig < 2 && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("rmid_reach_b2", n_trig, 2);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("rmid");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rmid_no_done", n_done, 0);
        clear_mon();
        start_dump(2, 2, e0);
        wait_done("rmid_restart_done", 400);
        check("rmid_b0", int'(byte_q[0]), 'h33);
        check("rmid_b1", int'(byte_q[1]), 'h44);
        check("rmid_count", done_count, 2);

`ifdef DUMP_CHECKSUM_EN
        clear_mon();
        start_dump(20, 2, e0);
        wait_done("csum_done", 400);
        check("csum_ntrig", n_trig, 3);
        check("csum_b0", int'(byte_q[0]), 'hF0);
        check("csum_b1", int'(byte_q[1]), 'h20);
        check("csum_sum", int'(byte_q[2]), 'h10);
        check("csum_count", done_count, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
